dct_transpose_buffer: RTL and testbench

DCT_TRANSPOSE_BUFFER -- requirements
Module: dct_transpose_buffer

---
 rtl/dct_transpose_buffer.sv | 134 +++++++++++++
 tb/tb_dct_transpose_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer
//   Ping-pong 8x8 transpose buffer between the row and column stages of a
//   2-D DCT. Rows are written into one bank while the other bank is read out
//   column by column; a bank becomes readable only once all 8 rows are in.
// Ports
//   Clk, Rst                 clock, synchronous active-high reset
//   In_Valid/In_Ready        row handshake, In_Data_0..7 = row coefficients
//   Out_Valid/Out_Ready      column handshake, Out_Data_k = element from row k
//   Out_Col                  index of the column being presented
//   Out_Last                 presenting column 7

// One row of both banks. Instance k holds row k of bank 0 and bank 1 and
// returns the element at the requested column of the requested bank.
module dct_transpose_row #(
  parameter int WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic                  wsel,
  input  logic [7:0][WIDTH-1:0] wdata,
  input  logic                  rsel,
  input  logic [2:0]            rcol,
  output logic [WIDTH-1:0]      rdata
);
  logic [7:0][WIDTH-1:0] mem [2];

  // Storage is deliberately not reset: the full flags gate all reads.
  always_ff @(posedge Clk) begin
    if (we) mem[wsel] <= wdata;
  end

  assign rdata = mem[rsel][rcol];
endmodule

module dct_transpose_buffer #(
  parameter int WIDTH = 10
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic signed [WIDTH-1:0] In_Data_0,
  input  logic signed [WIDTH-1:0] In_Data_1,
  input  logic signed [WIDTH-1:0] In_Data_2,
  input  logic signed [WIDTH-1:0] In_Data_3,
  input  logic signed [WIDTH-1:0] In_Data_4,
  input  logic signed [WIDTH-1:0] In_Data_5,
  input  logic signed [WIDTH-1:0] In_Data_6,
  input  logic signed [WIDTH-1:0] In_Data_7,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic signed [WIDTH-1:0] Out_Data_0,
  output logic signed [WIDTH-1:0] Out_Data_1,
  output logic signed [WIDTH-1:0] Out_Data_2,
  output logic signed [WIDTH-1:0] Out_Data_3,
  output logic signed [WIDTH-1:0] Out_Data_4,
  output logic signed [WIDTH-1:0] Out_Data_5,
  output logic signed [WIDTH-1:0] Out_Data_6,
  output logic signed [WIDTH-1:0] Out_Data_7,
  output logic [2:0]              Out_Col,
  output logic                    Out_Last
);
  logic [1:0]            full, full_nxt;
  logic                  wb, rb;
  logic [2:0]            wr_row, rd_col;
  logic                  in_fire, out_fire;
  logic [7:0][WIDTH-1:0] in_row, rd_data;

  assign in_row = {In_Data_7, In_Data_6, In_Data_5, In_Data_4,
                   In_Data_3, In_Data_2, In_Data_1, In_Data_0};

  assign In_Ready  = !full[wb];
  assign Out_Valid = full[rb];
  assign in_fire   = In_Valid && In_Ready;
  assign out_fire  = Out_Valid && Out_Ready;

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_row
      dct_transpose_row #(.WIDTH(WIDTH)) u_row (
        .Clk   (Clk),
        .we    (in_fire && !Rst && (wr_row == 3'(k))),
        .wsel  (wb),
        .wdata (in_row),
        .rsel  (rb),
        .rcol  (rd_col),
        .rdata (rd_data[k])
      );
    end
  endgenerate

  // A fill and a drain can land on the same edge; they always target
  // different banks (fill needs !full[wb], drain needs full[rb]).
  always_comb begin
    full_nxt = full;
    if (in_fire && wr_row == 3'd7)  full_nxt[wb] = 1'b1;
    if (out_fire && rd_col == 3'd7) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      full <= full_nxt;
      // 3-bit counters wrap 7 -> 0 on their own
      if (in_fire) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) wb <= ~wb;
      end
      if (out_fire) begin
        rd_col <= rd_col + 3'd1;
        if (rd_col == 3'd7) rb <= ~rb;
      end
    end
  end

  logic [7:0][WIDTH-1:0] out_bus;
  assign out_bus  = Out_Valid ? rd_data : '0;
  assign Out_Col  = rd_col;
  assign Out_Last = Out_Valid && (rd_col == 3'd7);

  assign Out_Data_0 = out_bus[0];
  assign Out_Data_1 = out_bus[1];
  assign Out_Data_2 = out_bus[2];
  assign Out_Data_3 = out_bus[3];
  assign Out_Data_4 = out_bus[4];
  assign Out_Data_5 = out_bus[5];
  assign Out_Data_6 = out_bus[6];
  assign Out_Data_7 = out_bus[7];
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: random and directed rows, checked every
// cycle against a block-queue model of the buffer.
module tb_dct_transpose_buffer;
  localparam int W = 10;

  typedef logic signed [W-1:0] row_t [8];
  typedef logic signed [W-1:0] blk_t [8][8];

  logic Clk = 1'b0, Rst = 1'b1, In_Valid = 1'b0, Out_Ready = 1'b0;
  logic In_Ready, Out_Valid, Out_Last;
  logic [2:0] Out_Col;
  logic signed [W-1:0] In_Data_0 = '0, In_Data_1 = '0, In_Data_2 = '0, In_Data_3 = '0;
  logic signed [W-1:0] In_Data_4 = '0, In_Data_5 = '0, In_Data_6 = '0, In_Data_7 = '0;
  logic signed [W-1:0] Out_Data_0, Out_Data_1, Out_Data_2, Out_Data_3;
  logic signed [W-1:0] Out_Data_4, Out_Data_5, Out_Data_6, Out_Data_7;

  dct_transpose_buffer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Data_0(In_Data_0), .In_Data_1(In_Data_1), .In_Data_2(In_Data_2), .In_Data_3(In_Data_3),
    .In_Data_4(In_Data_4), .In_Data_5(In_Data_5), .In_Data_6(In_Data_6), .In_Data_7(In_Data_7),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Data_0(Out_Data_0), .Out_Data_1(Out_Data_1), .Out_Data_2(Out_Data_2), .Out_Data_3(Out_Data_3),
    .Out_Data_4(Out_Data_4), .Out_Data_5(Out_Data_5), .Out_Data_6(Out_Data_6), .Out_Data_7(Out_Data_7),
    .Out_Col(Out_Col), .Out_Last(Out_Last)
  );

  always #5 Clk = ~Clk;

  wire [8*W-1:0] act_data = {Out_Data_7, Out_Data_6, Out_Data_5, Out_Data_4,
                             Out_Data_3, Out_Data_2, Out_Data_1, Out_Data_0};
  wire [5:0] act_ctrl = {In_Ready, Out_Valid, Out_Last, Out_Col};

  int checks = 0, passes = 0;

  // Model: queue of complete blocks awaiting readout, plus the block being filled.
  blk_t q[$];
  blk_t cur;
  int   cur_row = 0, rdc = 0;
  int   n_in = 0, n_out = 0;
  logic in_f, out_f, rst_m;
  row_t din;

  function automatic logic [5:0] exp_ctrl();
    logic v;
    v = q.size() > 0;
    return {q.size() < 2, v, v && rdc == 7, 3'(rdc)};
  endfunction

  function automatic logic [8*W-1:0] exp_data();
    logic [8*W-1:0] r;
    r = '0;
    if (q.size() > 0)
      for (int k = 0; k < 8; k++) r[k*W +: W] = q[0][k][rdc];
    return r;
  endfunction

  task automatic drive(input logic rst, input logic iv, input logic ordy, input row_t d);
    Rst = rst; In_Valid = iv; Out_Ready = ordy;
    In_Data_0 = d[0]; In_Data_1 = d[1]; In_Data_2 = d[2]; In_Data_3 = d[3];
    In_Data_4 = d[4]; In_Data_5 = d[5]; In_Data_6 = d[6]; In_Data_7 = d[7];
    din = d; rst_m = rst;
    in_f  = iv && q.size() < 2;
    out_f = ordy && q.size() > 0;
  endtask

  task automatic model_step();
    if (rst_m) begin
      q.delete(); cur_row = 0; rdc = 0;
    end else begin
      if (out_f) begin
        n_out++; rdc++;
        if (rdc == 8) begin rdc = 0; void'(q.pop_front()); end
      end
      if (in_f) begin
        n_in++;
        cur[cur_row] = din; cur_row++;
        if (cur_row == 8) begin q.push_back(cur); cur_row = 0; end
      end
    end
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int c = 0; c < 8; c++) r[c] = W'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    row_t d;
    d = rand_row();
    drive(1'b1, 1'b1, 1'b1, d);
    repeat (2) @(posedge Clk);
    model_step();
    @(negedge Clk);
    checks++;
    if (act_ctrl !== 6'b100000) $display("FAIL reset ctrl: got %b exp %b", act_ctrl, 6'b100000);
    else passes++;
    checks++;
    if (act_data !== '0) $display("FAIL reset data: got %h exp 0", act_data);
    else passes++;
    drive(1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic test_single_block();
    row_t d; int out0, lasts;
    out0 = n_out; lasts = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      checks++;
      if (act_ctrl !== exp_ctrl()) $display("FAIL single ctrl cyc %0d: got %b exp %b", i, act_ctrl, exp_ctrl());
      else passes++;
      checks++;
      if (act_data !== exp_data()) $display("FAIL single data cyc %0d: got %h exp %h", i, act_data, exp_data());
      else passes++;
      if (Out_Last) lasts++;
      for (int c = 0; c < 8; c++) d[c] = W'(8 * i + c);
      drive(1'b0, i < 8, 1'b1, d);
      @(posedge Clk); model_step();
    end
    checks++;
    if (n_out - out0 != 8 || lasts != 1) $display("FAIL single count: got %0d cols %0d lasts exp 8 cols 1 last", n_out - out0, lasts);
    else passes++;
  endtask

  task automatic test_signed();
    row_t d;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      checks++;
      if (act_ctrl !== exp_ctrl()) $display("FAIL signed ctrl cyc %0d: got %b exp %b", i, act_ctrl, exp_ctrl());
      else passes++;
      checks++;
      if (act_data !== exp_data()) $display("FAIL signed data cyc %0d: got %h exp %h", i, act_data, exp_data());
      else passes++;
      for (int c = 0; c < 8; c++) d[c] = ((i + c) % 2 != 0) ? W'(511) : W'(-512);
      drive(1'b0, i < 8, 1'b1, d);
      @(posedge Clk); model_step();
    end
  endtask

  task automatic test_backpressure();
    int stall, out0;
    logic ordy;
    stall = 0; out0 = n_out;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      checks++;
      if (act_ctrl !== exp_ctrl()) $display("FAIL bp ctrl cyc %0d: got %b exp %b", i, act_ctrl, exp_ctrl());
      else passes++;
      checks++;
      if (act_data !== exp_data()) $display("FAIL bp data cyc %0d: got %h exp %h", i, act_data, exp_data());
      else passes++;
      ordy = 1'b1;
      if (q.size() > 0 && rdc == 3 && stall < 5) begin ordy = 1'b0; stall++; end
      drive(1'b0, i < 8, ordy, rand_row());
      @(posedge Clk); model_step();
    end
    checks++;
    if (n_out - out0 != 8 || stall != 5) $display("FAIL bp count: got %0d cols %0d stalls exp 8 cols 5 stalls", n_out - out0, stall);
    else passes++;
  endtask

  task automatic test_both_full();
    int in0, out0, in16_at, in17_at, out8_at;
    in0 = n_in; out0 = n_out; in17_at = -1; out8_at = -1;
    in16_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      checks++;
      if (act_ctrl !== exp_ctrl()) $display("FAIL full ctrl cyc %0d: got %b exp %b", i, act_ctrl, exp_ctrl());
      else passes++;
      checks++;
      if (act_data !== exp_data()) $display("FAIL full data cyc %0d: got %h exp %h", i, act_data, exp_data());
      else passes++;
      if (i == 24) begin
        checks++;
        if (n_in - in0 != 16 || In_Ready !== 1'b0) $display("FAIL full stall: got %0d rows ready %b exp 16 rows ready 0", n_in - in0, In_Ready);
        else passes++;
      end
      drive(1'b0, (n_in - in0) < 24, i >= 25, rand_row());
      @(posedge Clk); model_step();
      if (n_in - in0 == 16 && in16_at < 0) in16_at = i;
      if (n_in - in0 == 17 && in17_at < 0) in17_at = i;
      if (n_out - out0 == 8 && out8_at < 0) out8_at = i;
    end
    checks++;
    if (in17_at != out8_at + 1 || in16_at != 15) $display("FAIL full resume: got row16@%0d row17@%0d col8@%0d exp row16@15 row17=col8+1", in16_at, in17_at, out8_at);
    else passes++;
  endtask

  task automatic test_streaming();
    int out0, first, last, not_ready;
    out0 = n_out; first = -1; last = -1; not_ready = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge Clk);
      checks++;
      if (act_ctrl !== exp_ctrl()) $display("FAIL stream ctrl cyc %0d: got %b exp %b", i, act_ctrl, exp_ctrl());
      else passes++;
      checks++;
      if (act_data !== exp_data()) $display("FAIL stream data cyc %0d: got %h exp %h", i, act_data, exp_data());
      else passes++;
      if (i < 32 && In_Ready !== 1'b1) not_ready++;
      drive(1'b0, i < 32, 1'b1, rand_row());
      @(posedge Clk); model_step();
      if (out_f) begin if (first < 0) first = i; last = i; end
    end
    checks++;
    if (n_out - out0 != 32 || last - first != 31 || first != 8 || not_ready != 0)
      $display("FAIL stream timing: got %0d cols first %0d last %0d notready %0d exp 32 cols first 8 last 39 notready 0",
               n_out - out0, first, last, not_ready);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int out0;
    out0 = n_out;
    for (int i = 0; i < 35; i++) begin
      @(negedge Clk);
      checks++;
      if (act_ctrl !== exp_ctrl()) $display("FAIL rstmid ctrl cyc %0d: got %b exp %b", i, act_ctrl, exp_ctrl());
      else passes++;
      checks++;
      if (act_data !== exp_data()) $display("FAIL rstmid data cyc %0d: got %h exp %h", i, act_data, exp_data());
      else passes++;
      // one full block held back, five more rows, reset (with handshakes offered), then a fresh block
      drive(i == 13, i != 13 && i < 22, i >= 13, rand_row());
      @(posedge Clk); model_step();
    end
    checks++;
    if (n_out - out0 != 8) $display("FAIL rstmid count: got %0d cols exp 8", n_out - out0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_signed();
    test_backpressure();
    test_both_full();
    test_streaming();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
